// File: rtl/riscv_hpc_pkg.sv
// ---------------------------------------------------------------------------
// riscv_hpc_pkg
// Shared definitions for the instruction-class performance counter bank.
//   - RV32 major opcode values (instruction bits [6:0])
//   - class index constants and the class count
//   - one-hot class vector type and a small helper
// Build option: HPC_SATURATE_EN (used by riscv_hpc_counter) selects saturating
// counters instead of wrapping ones.
// ---------------------------------------------------------------------------
package riscv_hpc_pkg;

    // RV32 major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Class indices; also the rd_sel_i encoding
    localparam int CLS_R     = 0;
    localparam int CLS_I     = 1;
    localparam int CLS_S     = 2;
    localparam int CLS_B     = 3;
    localparam int CLS_U     = 4;
    localparam int CLS_J     = 5;
    localparam int CLS_OTHER = 6;
    localparam int NUM_CLS   = 7;

    typedef logic [NUM_CLS-1:0] cls_vec_t;

    // One-hot vector with only bit idx set
    function automatic cls_vec_t cls_onehot(input int idx);
        cls_vec_t v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/riscv_hpc_counter.sv
// ---------------------------------------------------------------------------
// riscv_hpc_counter
// Single event counter of width CNT_W.
//   clk   in  1      clock, posedge
//   srst  in  1      synchronous active-high reset (count -> 0)
//   inc   in  1      add one this cycle
//   clr   in  1      zero the counter; wins over a simultaneous inc
//   count out CNT_W  current value
// Build option: define HPC_SATURATE_EN to make the counter stick at all-ones;
// otherwise it wraps all-ones -> 0.
// ---------------------------------------------------------------------------
module riscv_hpc_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc) begin
`ifdef HPC_SATURATE_EN
            if (count_reg != {CNT_W{1'b1}}) begin
                count_next = count_reg + CNT_W'(1);
            end
`else
            count_next = count_reg + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/riscv_hpc_inst_class_counter.sv
// ---------------------------------------------------------------------------
// riscv_hpc_inst_class_counter
// Performance counter bank that classifies each committed RV32 instruction by
// its major opcode (R/I/S/B/U/J/other) and counts each class.
// Pipeline: stage 1 registers a one-hot class for a valid, enabled commit;
// stage 2 increments the flagged counter. A commit at cycle N is visible on
// HPC_req_* from cycle N+2.
// Ports:
//   clk_i, rst_i             clock / synchronous active-high reset
//   commit_valid_i, commit_inst_i   committed instruction
//   cnt_en_i                 counting enable (sampled at stage 1 only)
//   clr_i                    zero all counters, drop stage-1 entry and the
//                            commit presented in the same cycle
//   rd_req_i, rd_sel_i       read request and counter select (7 reads 0)
//   rd_ack_o, rd_data_o      read response one cycle after the request;
//                            data holds its last value between reads
//   HPC_req_*                live counter values
// Build option: HPC_SATURATE_EN -> counters saturate instead of wrapping.
// ---------------------------------------------------------------------------
module riscv_hpc_inst_class_counter
    import riscv_hpc_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int SEL_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             commit_valid_i,
    input  logic [31:0]      commit_inst_i,
    input  logic             cnt_en_i,
    input  logic             clr_i,
    input  logic             rd_req_i,
    input  logic [SEL_W-1:0] rd_sel_i,
    output logic             rd_ack_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic [CNT_W-1:0] HPC_req_Rtype,
    output logic [CNT_W-1:0] HPC_req_Itype,
    output logic [CNT_W-1:0] HPC_req_Stype,
    output logic [CNT_W-1:0] HPC_req_Btype,
    output logic [CNT_W-1:0] HPC_req_Utype,
    output logic [CNT_W-1:0] HPC_req_Jtype,
    output logic [CNT_W-1:0] HPC_req_other
);

    localparam int NUM_SEL = 2 ** SEL_W;

    // Only the major opcode drives classification
    logic unused_inst_hi;
    assign unused_inst_hi = ^commit_inst_i[31:7];

    // ---------------- classifier (combinational) ----------------
    cls_vec_t cls_dec;

    always_comb begin
        cls_dec = '0;
        case (commit_inst_i[6:0])
            OPC_OP:      cls_dec = cls_onehot(CLS_R);
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR,
            OPC_SYSTEM,
            OPC_FENCE:   cls_dec = cls_onehot(CLS_I);
            OPC_STORE:   cls_dec = cls_onehot(CLS_S);
            OPC_BRANCH:  cls_dec = cls_onehot(CLS_B);
            OPC_LUI,
            OPC_AUIPC:   cls_dec = cls_onehot(CLS_U);
            OPC_JAL:     cls_dec = cls_onehot(CLS_J);
            default:     cls_dec = cls_onehot(CLS_OTHER);
        endcase
    end

    // ---------------- stage 1: registered class ----------------
    cls_vec_t cls_reg;
    cls_vec_t cls_next;

    // A clear drops both the entry already in stage 1 (its counter is zeroed
    // this edge anyway) and the commit arriving in the clear cycle.
    always_comb begin
        cls_next = '0;
        if (!clr_i && commit_valid_i && cnt_en_i) begin
            cls_next = cls_dec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cls_reg <= '0;
        end else begin
            cls_reg <= cls_next;
        end
    end

    // ---------------- stage 2: counters ----------------
    logic [CNT_W-1:0] cnt_val [NUM_CLS];

    generate
        for (genvar gi = 0; gi < NUM_CLS; gi++) begin : g_cnt
            riscv_hpc_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk_i),
                .srst  (rst_i),
                .inc   (cls_reg[gi]),
                .clr   (clr_i),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign HPC_req_Rtype = cnt_val[CLS_R];
    assign HPC_req_Itype = cnt_val[CLS_I];
    assign HPC_req_Stype = cnt_val[CLS_S];
    assign HPC_req_Btype = cnt_val[CLS_B];
    assign HPC_req_Utype = cnt_val[CLS_U];
    assign HPC_req_Jtype = cnt_val[CLS_J];
    assign HPC_req_other = cnt_val[CLS_OTHER];

    // ---------------- read port ----------------
    // Full 2**SEL_W table so every select value has a defined entry; selects
    // past the last class read as zero.
    logic [CNT_W-1:0] rd_tbl [NUM_SEL];

    generate
        for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_rd_tbl
            if (gi < NUM_CLS) begin : g_cls
                assign rd_tbl[gi] = cnt_val[gi];
            end else begin : g_zero
                assign rd_tbl[gi] = '0;
            end
        end
    endgenerate

    logic             rd_ack_reg;
    logic [CNT_W-1:0] rd_data_reg;
    logic [CNT_W-1:0] rd_data_next;

    // Counters are sampled from their registers, so a read sees the value
    // before any increment or clear taking effect on the same edge.
    always_comb begin
        rd_data_next = rd_data_reg;
        if (rd_req_i) begin
            rd_data_next = rd_tbl[rd_sel_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ack_reg  <= 1'b0;
            rd_data_reg <= '0;
        end else begin
            rd_ack_reg  <= rd_req_i;
            rd_data_reg <= rd_data_next;
        end
    end

    assign rd_ack_o  = rd_ack_reg;
    assign rd_data_o = rd_data_reg;

endmodule

// File: tb/tb_riscv_hpc_inst_class_counter.sv
// ---------------------------------------------------------------------------
// tb_riscv_hpc_inst_class_counter
// Drives a full-width counter bank (CNT_W=32) and a narrow one (CNT_W=4) with
// identical stimulus. A cycle-level behavioural model (per-class counts plus
// one pending classified commit) predicts every output after every edge; the
// narrow bank exercises counter overflow. Directed scenarios also check the
// literal values worked out for them. HPC_SATURATE_EN selects saturation.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_riscv_hpc_inst_class_counter;

    localparam int NW = 4;
    localparam longint MAX_W = 64'hFFFF_FFFF;
    localparam longint MAX_N = 64'hF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_inst = '0;
    logic        cnt_en = 1'b1;
    logic        clr = 1'b0;
    logic        rd_req = 1'b0;
    logic [2:0]  rd_sel = '0;

    logic        rd_ack, rd_ack_n;
    logic [31:0] rd_data;
    logic [NW-1:0] rd_data_n;
    logic [31:0] hw  [7];
    logic [NW-1:0] hwn [7];

    always #5 clk = ~clk;

    riscv_hpc_inst_class_counter dut (
        .clk_i(clk), .rst_i(rst), .commit_valid_i(commit_valid),
        .commit_inst_i(commit_inst), .cnt_en_i(cnt_en), .clr_i(clr),
        .rd_req_i(rd_req), .rd_sel_i(rd_sel), .rd_ack_o(rd_ack),
        .rd_data_o(rd_data),
        .HPC_req_Rtype(hw[0]), .HPC_req_Itype(hw[1]), .HPC_req_Stype(hw[2]),
        .HPC_req_Btype(hw[3]), .HPC_req_Utype(hw[4]), .HPC_req_Jtype(hw[5]),
        .HPC_req_other(hw[6])
    );

    riscv_hpc_inst_class_counter #(.CNT_W(NW), .SEL_W(3)) dut_n (
        .clk_i(clk), .rst_i(rst), .commit_valid_i(commit_valid),
        .commit_inst_i(commit_inst), .cnt_en_i(cnt_en), .clr_i(clr),
        .rd_req_i(rd_req), .rd_sel_i(rd_sel), .rd_ack_o(rd_ack_n),
        .rd_data_o(rd_data_n),
        .HPC_req_Rtype(hwn[0]), .HPC_req_Itype(hwn[1]), .HPC_req_Stype(hwn[2]),
        .HPC_req_Btype(hwn[3]), .HPC_req_Utype(hwn[4]), .HPC_req_Jtype(hwn[5]),
        .HPC_req_other(hwn[6])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_cnt [7];
    longint m_cntn[7];
    int     m_pend = -1;
    bit     m_ack = 0;
    longint m_data = 0, m_datan = 0;

    // Class from the instruction set's opcode table: R=0 I=1 S=2 B=3 U=4 J=5 other=6
    function automatic int class_of(input logic [31:0] inst);
        case (inst[6:0])
            7'h33:                             return 0;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return 1;
            7'h23:                             return 2;
            7'h63:                             return 3;
            7'h37, 7'h17:                      return 4;
            7'h6F:                             return 5;
            default:                           return 6;
        endcase
    endfunction

    function automatic longint bump(input longint v, input longint maxv);
`ifdef HPC_SATURATE_EN
        return (v == maxv) ? v : v + 1;
`else
        return (v == maxv) ? 0 : v + 1;
`endif
    endfunction

    task automatic model_edge(input bit v, input logic [31:0] inst, input bit en,
                              input bit c, input bit rq, input logic [2:0] sel, input bit r);
        if (r) begin
            for (int i = 0; i < 7; i++) begin m_cnt[i] = 0; m_cntn[i] = 0; end
            m_pend = -1; m_ack = 0; m_data = 0; m_datan = 0;
        end else begin
            m_ack = rq;
            if (rq) begin
                m_data  = (sel < 7) ? m_cnt[sel]  : 0;
                m_datan = (sel < 7) ? m_cntn[sel] : 0;
            end
            if (c) begin
                for (int i = 0; i < 7; i++) begin m_cnt[i] = 0; m_cntn[i] = 0; end
                m_pend = -1;
            end else begin
                if (m_pend >= 0) begin
                    m_cnt[m_pend]  = bump(m_cnt[m_pend], MAX_W);
                    m_cntn[m_pend] = bump(m_cntn[m_pend], MAX_N);
                end
                m_pend = (v && en) ? class_of(inst) : -1;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("cnt%0d", i), {32'd0, hw[i]}, m_cnt[i]);
            check_eq($sformatf("cntn%0d", i), {60'd0, hwn[i]}, m_cntn[i]);
        end
        check_eq("rd_ack", {63'd0, rd_ack}, {63'd0, m_ack});
        check_eq("rd_ack_n", {63'd0, rd_ack_n}, {63'd0, m_ack});
        check_eq("rd_data", {32'd0, rd_data}, m_data);
        check_eq("rd_data_n", {60'd0, rd_data_n}, m_datan);
    endtask

    // One clock: drive inputs, take the edge, update model, check 1ns later
    task automatic step(input bit v, input logic [31:0] inst, input bit en,
                        input bit c, input bit rq, input logic [2:0] sel, input bit r);
        commit_valid = v; commit_inst = inst; cnt_en = en;
        clr = c; rd_req = rq; rd_sel = sel; rst = r;
        @(posedge clk);
        model_edge(v, inst, en, c, rq, sel, r);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 1, 0, 0, 3'd0, 0);
    endtask

    task automatic commit(input logic [31:0] inst);
        step(1, inst, 1, 0, 0, 3'd0, 0);
    endtask

    logic [31:0] mix [7] = '{32'h00000013, 32'h00112623, 32'h00008067, 32'h000002b7,
                             32'h0000006f, 32'h00b50463, 32'h00b50533};
    logic [6:0] opc_pool [14] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                                  7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00, 7'h5B};

    initial begin
        int exp_mix [7];
        logic [31:0] inst_r;
        exp_mix = '{1, 2, 1, 1, 1, 1, 0};

        // Reset
        step(0, 0, 1, 0, 0, 3'd0, 1);
        step(0, 0, 1, 0, 0, 3'd0, 1);
        for (int i = 0; i < 7; i++) check_eq($sformatf("rst_cnt%0d", i), {32'd0, hw[i]}, 64'd0);
        check_eq("rst_ack", {63'd0, rd_ack}, 64'd0);
        check_eq("rst_data", {32'd0, rd_data}, 64'd0);
        $display("[tb] reset: counters/ack/data zero");

        // Mixed stream back-to-back
        for (int i = 0; i < 7; i++) commit(mix[i]);
        idle(2);
        for (int i = 0; i < 7; i++) check_eq($sformatf("mix_cls%0d", i), {32'd0, hw[i]}, 64'(exp_mix[i]));
        $display("[tb] mixed stream: R=%0d I=%0d S=%0d B=%0d U=%0d J=%0d other=%0d",
                 hw[0], hw[1], hw[2], hw[3], hw[4], hw[5], hw[6]);

        // Freeze and unknown opcode
        for (int i = 0; i < 3; i++) step(1, 32'h00000013, 0, 0, 0, 3'd0, 0);
        idle(2);
        check_eq("freeze_I", {32'd0, hw[1]}, 64'd2);
        commit(32'hFFFFFFFF);
        idle(2);
        check_eq("unknown_other", {32'd0, hw[6]}, 64'd1);
        $display("[tb] freeze: I=%0d other=%0d", hw[1], hw[6]);

        // Clear colliding with a commit
        step(0, 0, 1, 0, 0, 3'd0, 1);
        for (int i = 0; i < 5; i++) commit(32'h00000013);
        idle(2);
        check_eq("pre_clr_I", {32'd0, hw[1]}, 64'd5);
        commit(32'h00000013);               // in stage 1 when the clear lands
        step(1, 32'h00000013, 1, 1, 0, 3'd0, 0);
        idle(3);
        check_eq("clr_I", {32'd0, hw[1]}, 64'd0);
        $display("[tb] clear collision: I=%0d", hw[1]);

        // Read port
        step(0, 0, 1, 0, 0, 3'd0, 1);
        for (int i = 0; i < 17; i++) commit(32'h00000013);
        idle(2);
        step(1, 32'h00000013, 1, 0, 1, 3'd1, 0);
        check_eq("rd1_ack", {63'd0, rd_ack}, 64'd1);
        check_eq("rd1_data", {32'd0, rd_data}, 64'h11);
        idle(1);
        check_eq("rd1_ack_drop", {63'd0, rd_ack}, 64'd0);
        check_eq("rd1_hold", {32'd0, rd_data}, 64'h11);
        check_eq("rd1_I_after", {32'd0, hw[1]}, 64'h12);
        step(0, 0, 1, 0, 1, 3'd7, 0);
        check_eq("rd7_ack", {63'd0, rd_ack}, 64'd1);
        check_eq("rd7_data", {32'd0, rd_data}, 64'd0);
        step(0, 0, 1, 1, 1, 3'd1, 0);       // read with clear: pre-clear value
        check_eq("rdclr_data", {32'd0, rd_data}, 64'h12);
        step(0, 0, 1, 0, 1, 3'd1, 0);       // back-to-back read after clear
        check_eq("rdb2b_ack", {63'd0, rd_ack}, 64'd1);
        check_eq("rdb2b_data", {32'd0, rd_data}, 64'd0);
        $display("[tb] read port: last data=0x%0h", rd_data);

        // Overflow on the narrow bank: 17 R commits
        step(0, 0, 1, 0, 0, 3'd0, 1);
        for (int i = 0; i < 17; i++) commit(32'h00b50533);
        idle(2);
        check_eq("ovf_R_wide", {32'd0, hw[0]}, 64'd17);
`ifdef HPC_SATURATE_EN
        check_eq("ovf_R_narrow", {60'd0, hwn[0]}, 64'd15);
`else
        check_eq("ovf_R_narrow", {60'd0, hwn[0]}, 64'd1);
`endif
        $display("[tb] overflow: wide R=%0d narrow R=%0d", hw[0], hwn[0]);

        // Reset mid-operation discards stage 1 and pending ack
        commit(32'h00000013);
        step(1, 32'h00000013, 1, 0, 1, 3'd1, 0);
        step(1, 32'h00000013, 1, 0, 0, 3'd0, 1);
        check_eq("midrst_ack", {63'd0, rd_ack}, 64'd0);
        idle(2);
        check_eq("midrst_I", {32'd0, hw[1]}, 64'd0);
        $display("[tb] mid-op reset: I=%0d", hw[1]);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            inst_r = $urandom();
            inst_r[6:0] = opc_pool[$urandom_range(0, 13)];
            step($urandom_range(0, 3) != 0, inst_r, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                 3'($urandom_range(0, 7)), $urandom_range(0, 499) == 0);
        end
        $display("[tb] random: 3000 cycles done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
